// File: rtl/booth_mac_accumulator_if.sv
// Operand/result handshake bundle for booth_mac_accumulator.
// The producer/consumer side uses the master modport; the MAC uses slave.
interface booth_mac_accumulator_if #(
  parameter int unsigned ACC_W = 16
);
  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [3:0]       multiplicand;
  logic signed [3:0]       multiplier;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    overflow;

  modport master (
    output clear, in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  clear, in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/booth_mac_accumulator.sv
// Booth multiplier feeding a LEN-term signed dot-product accumulator.
// Define BOOTH_MAC_SATURATION_EN to clamp on overflow instead of wrapping.

// Radix-2 Booth recoding of a 4x4 signed product.
module booth_multiplier (
  input  logic signed [3:0] i_multiplicand,
  input  logic signed [3:0] i_multiplier,
  output logic signed [7:0] o_product
);
  logic signed [7:0] w_a;
  logic [4:0]        w_b;

  always_comb begin
    w_a       = 8'(i_multiplicand);
    w_b       = {i_multiplier, 1'b0};
    o_product = '0;
    for (int i = 0; i < 4; i++) begin
      case (w_b[i +: 2])
        2'b01:   o_product = o_product + (w_a <<< i);
        2'b10:   o_product = o_product - (w_a <<< i);
        default: o_product = o_product;
      endcase
    end
  end
endmodule

module booth_mac_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  booth_mac_accumulator_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [7:0]       w_product;
  logic signed [7:0]       r_prod;
  logic                    r_prod_v;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_add_ovf;
  logic                    r_ovf;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_out_hs;

  booth_multiplier u_mult (
    .i_multiplicand (bus.multiplicand),
    .i_multiplier   (bus.multiplier),
    .o_product      (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode; clear overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_ACC: begin
        w_in_ready = !bus.clear;
        if (w_in_ready && bus.in_valid && (r_cnt == CNT_W'(LEN - 1)))
          w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_ACC;
      end
      default: w_state_nxt = S_ACC;
    endcase
    if (bus.clear) w_state_nxt = S_ACC;
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_out_hs = w_out_valid && bus.out_ready;

  // Signed add with overflow when both addends agree in sign but the sum does not.
  assign w_ext     = ACC_W'(r_prod);
  assign w_sum     = r_acc + w_ext;
  assign w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_MAC_SATURATION_EN
  always_comb begin
    w_acc_nxt = w_sum;
    if (w_add_ovf)
      w_acc_nxt = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign w_acc_nxt = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_prod_v <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else if (bus.clear) begin
      r_prod_v <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_prod_v <= w_accept;
      if (w_accept) begin
        r_prod <= w_product;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (r_prod_v) begin
        r_acc <= w_acc_nxt;
        if (w_add_ovf) r_ovf <= 1'b1;
      end
      if (w_out_hs) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: a 16-bit instance for the main
// sequences and an 8-bit instance for the overflow case.
module tb_booth_mac_accumulator;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  booth_mac_accumulator_if #(.ACC_W(16)) bus16 ();
  booth_mac_accumulator_if #(.ACC_W(8))  bus8 ();

  booth_mac_accumulator #(.ACC_W(16), .LEN(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  booth_mac_accumulator #(.ACC_W(8), .LEN(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push16(input logic signed [3:0] a, input logic signed [3:0] b);
    bus16.in_valid     = 1'b1;
    bus16.multiplicand = a;
    bus16.multiplier   = b;
    tick();
  endtask

  task automatic push8(input logic signed [3:0] a, input logic signed [3:0] b);
    bus8.in_valid     = 1'b1;
    bus8.multiplicand = a;
    bus8.multiplier   = b;
    tick();
  endtask

  task automatic idle16();
    bus16.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus16.clear = 1'b0; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    bus16.multiplicand = '0; bus16.multiplier = '0;
    bus8.clear = 1'b0;  bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
    bus8.multiplicand = '0;  bus8.multiplier = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus16.out_valid), 0);
    chk("rst_acc_out",   32'(bus16.acc_out),   0);
    chk("rst_overflow",  32'(bus16.overflow),  0);
    #9 rst = 1'b0;
    tick();
    chk("rst_in_ready",  32'(bus16.in_ready),  1);

    // Back-to-back pairs: -15 -14 +8 +49 = 28
    push16(-4'sd3, 4'sd5);
    push16(4'sd2, -4'sd7);
    push16(-4'sd4, -4'sd2);
    push16(4'sd7, 4'sd7);
    bus16.in_valid = 1'b0;
    chk("t1_flush_out_valid", 32'(bus16.out_valid), 0);
    chk("t1_flush_in_ready",  32'(bus16.in_ready),  0);
    tick();
    chk("t1_out_valid", 32'(bus16.out_valid), 1);
    chk("t1_acc_out",   32'(bus16.acc_out),   28);
    chk("t1_overflow",  32'(bus16.overflow),  0);
    chk("t1_in_ready",  32'(bus16.in_ready),  0);
    tick();
    chk("t1_post_out_valid", 32'(bus16.out_valid), 0);
    chk("t1_post_acc_out",   32'(bus16.acc_out),   0);
    chk("t1_post_in_ready",  32'(bus16.in_ready),  1);

    // Same stimulus with back-pressure on the result
    bus16.out_ready = 1'b0;
    push16(-4'sd3, 4'sd5);
    push16(4'sd2, -4'sd7);
    push16(-4'sd4, -4'sd2);
    push16(4'sd7, 4'sd7);
    idle16();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_out_valid", 32'(bus16.out_valid), 1);
      chk("t2_hold_acc_out",   32'(bus16.acc_out),   28);
      chk("t2_hold_in_ready",  32'(bus16.in_ready),  0);
      tick();
    end
    bus16.out_ready = 1'b1;
    tick();
    chk("t2_post_acc_out",   32'(bus16.acc_out),   0);
    chk("t2_post_in_ready",  32'(bus16.in_ready),  1);
    chk("t2_post_out_valid", 32'(bus16.out_valid), 0);

    // Clear aborts a partial sum and blocks the pair offered alongside it
    push16(4'sd3, 4'sd3);
    push16(4'sd3, 4'sd3);
    chk("t3_no_early_valid", 32'(bus16.out_valid), 0);
    bus16.in_valid     = 1'b1;
    bus16.multiplicand = 4'sd3;
    bus16.multiplier   = 4'sd3;
    bus16.clear        = 1'b1;
    #1;
    chk("t3_clear_in_ready", 32'(bus16.in_ready), 0);
    tick();
    bus16.clear    = 1'b0;
    bus16.in_valid = 1'b0;
    chk("t3_cleared_acc", 32'(bus16.acc_out), 0);
    for (int i = 0; i < 4; i++) push16(4'sd1, 4'sd1);
    idle16();
    chk("t3_out_valid", 32'(bus16.out_valid), 1);
    chk("t3_acc_out",   32'(bus16.acc_out),   4);
    chk("t3_overflow",  32'(bus16.overflow),  0);
    tick();

    // Bubbles between accepts stall the count only
    for (int i = 0; i < 4; i++) begin
      push16(4'sd1, 4'sd2);
      if (i < 3) idle16();
    end
    bus16.in_valid = 1'b0;
    chk("t4_flush_out_valid", 32'(bus16.out_valid), 0);
    tick();
    chk("t4_out_valid", 32'(bus16.out_valid), 1);
    chk("t4_acc_out",   32'(bus16.acc_out),   8);
    tick();

    // 8-bit accumulator: four products of 64
    for (int i = 0; i < 4; i++) push8(4'sb1000, 4'sb1000);
    bus8.in_valid = 1'b0;
    tick();
    chk("t5_out_valid", 32'(bus8.out_valid), 1);
`ifdef BOOTH_MAC_SATURATION_EN
    chk("t5_acc_out",   32'(bus8.acc_out),   127);
`else
    chk("t5_acc_out",   32'(bus8.acc_out),   0);
`endif
    chk("t5_overflow",  32'(bus8.overflow),  1);
    tick();
    chk("t5_post_overflow", 32'(bus8.overflow), 0);

    // Asynchronous reset while holding a result
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push16(4'sd1, 4'sd1);
    idle16();
    chk("t6_done_out_valid", 32'(bus16.out_valid), 1);
    chk("t6_done_acc_out",   32'(bus16.acc_out),   4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(bus16.out_valid), 0);
    chk("t6_rst_acc_out",   32'(bus16.acc_out),   0);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_in_ready",  32'(bus16.in_ready),  1);
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push16(-4'sd3, 4'sd5);
    idle16();
    chk("t6_out_valid", 32'(bus16.out_valid), 1);
    chk("t6_acc_out",   32'(bus16.acc_out),   -60);
    chk("t6_overflow",  32'(bus16.overflow),  0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
